uart_rx_monitor: RTL and testbench
==================================

# uart_rx_monitor

Synthesizable 8N1 UART receiver that consumes the SweRVolf `o_uart_tx` serial line and presents decoded bytes on a ready/valid stream through a small FIFO. It sits directly downstream of the SoC UART pin in the simulation top level and in FPGA loopback builds. It replaces the behavioural UART decoder, so benches and on-chip checkers can assert console output cycle-accurately. Framing errors and FIFO overflow are reported as status flags.

## Interface
Parameters:
- `CLK_FREQ_HZ`, 50000000: clock frequency in Hz.
- `BAUD`, 115200: line rate. `CLKS_PER_BIT = CLK_FREQ_HZ/BAUD` (integer divide) must be ≥ 4.
- `FIFO_DEPTH`, 8: byte FIFO entries. Must be a power of 2 and ≥ 2.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `i_rx` in 1: serial input, idle high; asynchronous to `clk`.
- `o_data` out 8: head-of-FIFO byte; 8'h00 whenever `o_valid`=0.
- `o_valid` out 1: FIFO non-empty.
- `i_ready` in 1: consumer accepts `o_data` when `o_valid`&&`i_ready`.
- `o_count` out clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- `o_busy` out 1: receive FSM is not in IDLE.
- `o_frame_err` out 1: one-cycle pulse when a stop bit samples 0.
- `o_overflow` out 1: sticky; set when a good byte arrives with the FIFO full. Cleared only by `rst`.

## Operation
- `i_rx` passes through a 2-flop synchronizer (`rx_s`), whose reset value is 1. All FSM decisions use `rx_s`.
- Counters: `bit_cnt` (0..7) and `tick_cnt` (0..CLKS_PER_BIT-1). Define `HALF = CLKS_PER_BIT/2`.
- FSM states:
  - IDLE: when `rx_s`=0, clear `tick_cnt` and go to START.
  - START: count HALF-1 ticks, then sample `rx_s`. If 0, clear `tick_cnt` and `bit_cnt` and go to DATA. If 1 (glitch or false start), return to IDLE with no flag.
  - DATA: count CLKS_PER_BIT-1 ticks, then sample `rx_s` into `shift[bit_cnt]` (LSB first). After bit 7, go to STOP; otherwise increment `bit_cnt`.
  - STOP: count CLKS_PER_BIT-1 ticks, then sample `rx_s`.
    - If 1: push `shift` into the FIFO and go to IDLE.
    - If 0: pulse `o_frame_err`, discard the byte, and go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rx_s`=1, then go to IDLE. This prevents a break condition from generating repeated frames.
- FIFO: first-word fall-through, with registered write and read pointers of width clog2(FIFO_DEPTH)+1.
  - push = good stop bit. pop = `o_valid`&&`i_ready`.
  - Push when full and no pop: byte dropped, `o_overflow` set, contents unchanged.
  - Push and pop in the same cycle when full: both happen; no overflow; `o_count` unchanged.
  - Push and pop in the same cycle when empty: not possible, since `o_valid`=0.
  - Pointers wrap modulo 2·FIFO_DEPTH. Full when the addresses are equal and the MSBs differ.
- Reset, including mid-frame:
  - FSM → IDLE; FIFO emptied; `o_overflow` cleared.
  - Any partial byte is lost.
  - Synchronizer flops are set to 1, so no spurious start is seen.

## Timing
- Reset values: `o_data`=0, `o_valid`=0, `o_count`=0, `o_busy`=0, `o_frame_err`=0, `o_overflow`=0.
- Let T0 be the first cycle with `rx_s`=0 in IDLE. T0 is 2–3 cycles after the `i_rx` fall (synchronizer latency).
  - Start sample at T0+HALF.
  - Data bit k sampled at T0+HALF+(k+1)·CLKS_PER_BIT.
  - Stop sampled at T0+HALF+9·CLKS_PER_BIT.
- `o_valid`/`o_data`/`o_count` update the cycle after the stop sample (1-cycle push latency). `o_frame_err` is asserted that same cycle.
- The FSM is in IDLE the cycle after a good stop sample. A start bit that follows immediately (mid-stop + ½ bit) is detected.
- A pop is visible next cycle: `o_count` decrements, and `o_data` shows the next entry or 0.
- `o_busy` is high from T0+1 through the cycle in which the FSM returns to IDLE.

## Test plan
Unless noted, use `CLK_FREQ_HZ`=16, `BAUD`=1 (`CLKS_PER_BIT`=16), `FIFO_DEPTH`=4, and `i_ready`=1.
- Single frame 0xA5:
  - `o_valid` pulses 1 cycle with `o_data`=8'hA5.
  - `o_frame_err` stays 0, and `o_count` returns to 0.
- Back-to-back 0x00, 0xFF, 0x55 with no idle gap, and `i_ready`=0:
  - `o_count` reaches 3.
  - Then raising `i_ready` pops 00, FF, 55 on consecutive cycles.
- Frame 0x3C with the stop bit forced 0, then line low for 40 cycles:
  - Exactly one `o_frame_err` pulse.
  - No push, and `o_busy` stays high until the line returns high.
- 6-cycle low glitch on idle line: no push, no `o_frame_err`, FSM back in IDLE.
- Overflow with `i_ready`=0 and 5 frames 0x01..0x05:
  - `o_count`=4 and `o_overflow`=1.
  - Pops yield 01..04.
  - Repeat with a pop coinciding with the 5th push: no overflow, 05 retained.
- Reset asserted at the data-bit-3 sample:
  - Next cycle all outputs are at reset values.
  - A subsequent frame 0x7E decodes correctly.

Source files
------------

// File: rtl/uart_rx_monitor.sv
// 8N1 UART receiver with a first-word fall-through byte FIFO on a ready/valid stream.
// Reports stop-bit framing errors as a one-cycle pulse and FIFO overflow as a sticky flag.
module uart_rx_monitor #(
    parameter int unsigned CLK_FREQ_HZ = 50000000,
    parameter int unsigned BAUD        = 115200,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_rx,
    output logic [7:0]                    o_data,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_count,
    output logic                          o_busy,
    output logic                          o_frame_err,
    output logic                          o_overflow
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
    localparam int unsigned HALF         = CLKS_PER_BIT / 2;
    localparam int unsigned TW           = $clog2(CLKS_PER_BIT);
    localparam int unsigned AW           = $clog2(FIFO_DEPTH);
    localparam logic [TW-1:0] TICK_HALF  = TW'(HALF - 1);
    localparam logic [TW-1:0] TICK_FULL  = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitHigh} state_e;

    logic          rx_meta;
    logic          rx_s;
    state_e        state;
    logic [TW-1:0] tick_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          bit_done;
    logic          push;

    // Synchronizer resets to idle-high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
        end
    end

    assign bit_done = (tick_cnt == TICK_FULL);
    assign push     = (state == StStop) && bit_done && rx_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= StIdle;
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            o_busy      <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_frame_err <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (!rx_s) begin
                        tick_cnt <= '0;
                        state    <= StStart;
                        o_busy   <= 1'b1;
                    end
                end
                StStart: begin
                    if (tick_cnt == TICK_HALF) begin
                        if (!rx_s) begin
                            tick_cnt <= '0;
                            bit_cnt  <= '0;
                            state    <= StData;
                        end else begin
                            state  <= StIdle;
                            o_busy <= 1'b0;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                StData: begin
                    if (bit_done) begin
                        shift[bit_cnt] <= rx_s;
                        tick_cnt       <= '0;
                        if (bit_cnt == 3'd7) begin
                            state <= StStop;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                StStop: begin
                    if (bit_done) begin
                        tick_cnt <= '0;
                        if (rx_s) begin
                            state  <= StIdle;
                            o_busy <= 1'b0;
                        end else begin
                            o_frame_err <= 1'b1;
                            state       <= StWaitHigh;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                StWaitHigh: begin
                    // Hold off through a break so a long low line yields one error only.
                    if (rx_s) begin
                        state  <= StIdle;
                        o_busy <= 1'b0;
                    end
                end
                default: begin
                    state  <= StIdle;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [7:0]  mem [FIFO_DEPTH];
    logic        full;
    logic        pop;
    logic        wr_en;

    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign o_valid = (wr_ptr != rd_ptr);
    assign pop     = o_valid && i_ready;
    // A pop frees the head slot in the same cycle, so a full FIFO still accepts.
    assign wr_en   = push && (!full || pop);
    assign o_count = wr_ptr - rd_ptr;
    assign o_data  = o_valid ? mem[rd_ptr[AW-1:0]] : 8'h00;

    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem[wr_ptr[AW-1:0]] <= shift;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && full && !pop) begin
                o_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Scoreboard bench for uart_rx_monitor: frames are driven serially, expected bytes queued,
// and a negedge monitor compares every accepted output byte against the queue.
module tb_uart_rx_monitor;

    localparam int CPB      = 16;
    localparam int HALF     = CPB / 2;
    localparam int DEPTH    = 4;
    localparam int STOP_CYC = 2 + HALF + 9 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_rx = 1'b1;
    logic       i_ready = 1'b1;
    logic [7:0] o_data;
    logic       o_valid;
    logic [2:0] o_count;
    logic       o_busy;
    logic       o_frame_err;
    logic       o_overflow;

    uart_rx_monitor #(
        .CLK_FREQ_HZ(16),
        .BAUD       (1),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_rx       (i_rx),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_count    (o_count),
        .o_busy     (o_busy),
        .o_frame_err(o_frame_err),
        .o_overflow (o_overflow)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    logic [7:0] exp_q[$];
    bit         exp_ovf = 0;
    int         exp_ferr = 0;
    int         ferr_seen = 0;
    int         valid_cycles = 0;
    bit         mon_en = 0;
    bit         rnd_on = 0;

    task automatic check(input string name, input int unsigned act, input int unsigned req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (o_valid) valid_cycles++;
            if (o_frame_err) ferr_seen++;
            if (!o_valid) check("data_zero_when_invalid", o_data, 0);
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pop: got %0h, expected no output", o_data);
                end else begin
                    check("pop_data", o_data, exp_q.pop_front());
                end
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        i_ready = 1'b0;
        exp_q.delete();
        exp_ovf = 0;
        idle(2);
        rst = 1'b0;
    endtask

    // Drives one 8N1 frame, one cycle per iteration. pop_cyc raises i_ready for that cycle
    // only; rst_cyc aborts the frame with a reset and checks reset values.
    task automatic send_frame(input logic [7:0] b, input bit stop_val,
                              input int pop_cyc, input int rst_cyc);
        logic [9:0] bits;
        bits = {stop_val, b, 1'b0};
        for (int c = 0; c < 10 * CPB; c++) begin
            @(posedge clk);
            #1;
            i_rx = bits[c / CPB];
            if (c == pop_cyc) i_ready = 1'b1;
            if (pop_cyc >= 0 && c == pop_cyc + 1) i_ready = 1'b0;
            if (c == rst_cyc) begin
                rst = 1'b1;
                exp_q.delete();
                exp_ovf = 0;
                @(posedge clk);
                #1;
                rst = 1'b0;
                i_rx = 1'b1;
                #2;
                check("rst_mid_data", o_data, 0);
                check("rst_mid_valid", o_valid, 0);
                check("rst_mid_count", o_count, 0);
                check("rst_mid_busy", o_busy, 0);
                check("rst_mid_ferr", o_frame_err, 0);
                check("rst_mid_ovf", o_overflow, 0);
                return;
            end
            if (c == STOP_CYC) begin
                #1;
                if (stop_val) begin
                    if (exp_q.size() >= DEPTH && !i_ready) exp_ovf = 1;
                    else exp_q.push_back(b);
                end else begin
                    exp_ferr++;
                end
            end
            if (c == STOP_CYC + 1) begin
                #2;
                check("count_after_stop", o_count, exp_q.size());
                check("ferr_after_stop", o_frame_err, !stop_val);
                check("ovf_after_stop", o_overflow, exp_ovf);
            end
        end
    endtask

    initial begin
        int vc0;
        int busy_low;
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        #2;
        check("reset_data", o_data, 0);
        check("reset_valid", o_valid, 0);
        check("reset_count", o_count, 0);
        check("reset_busy", o_busy, 0);
        check("reset_ferr", o_frame_err, 0);
        check("reset_ovf", o_overflow, 0);
        mon_en = 1;

        // Single frame
        vc0 = valid_cycles;
        send_frame(8'hA5, 1'b1, -1, -1);
        idle(5);
        check("single_valid_cycles", valid_cycles - vc0, 1);
        check("single_ferr", ferr_seen, exp_ferr);
        check("single_count", o_count, 0);

        // Back-to-back with consumer stalled, then consecutive pops
        i_ready = 1'b0;
        send_frame(8'h00, 1'b1, -1, -1);
        send_frame(8'hFF, 1'b1, -1, -1);
        send_frame(8'h55, 1'b1, -1, -1);
        idle(3);
        check("b2b_count", o_count, 3);
        i_ready = 1'b1;
        for (int k = 2; k >= 0; k--) begin
            @(posedge clk);
            #3;
            check("b2b_drain_count", o_count, k);
        end
        idle(2);

        // Framing error followed by a break
        vc0 = valid_cycles;
        send_frame(8'h3C, 1'b0, -1, -1);
        busy_low = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            i_rx = 1'b0;
            if (!o_busy) busy_low++;
        end
        check("break_busy_held", busy_low, 0);
        i_rx = 1'b1;
        idle(6);
        check("break_busy_released", o_busy, 0);
        check("break_one_ferr", ferr_seen, exp_ferr);
        check("break_no_push", valid_cycles - vc0, 0);

        // Short glitch on idle line
        vc0 = valid_cycles;
        i_rx = 1'b0;
        idle(6);
        i_rx = 1'b1;
        idle(30);
        check("glitch_busy", o_busy, 0);
        check("glitch_no_push", valid_cycles - vc0, 0);
        check("glitch_no_ferr", ferr_seen, exp_ferr);

        // Overflow
        i_ready = 1'b0;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, -1, -1);
        idle(2);
        check("ovf_count", o_count, 4);
        check("ovf_flag", o_overflow, 1);
        i_ready = 1'b1;
        idle(6);
        check("ovf_drained", o_count, 0);
        check("ovf_sticky", o_overflow, 1);

        // Reset at the data-bit-3 sample, with a byte pending
        i_ready = 1'b0;
        send_frame(8'h11, 1'b1, -1, -1);
        send_frame(8'h7E, 1'b1, -1, 2 + HALF + 4 * CPB);
        idle(20);
        i_ready = 1'b1;
        send_frame(8'h7E, 1'b1, -1, -1);
        idle(4);
        check("after_rst_empty", exp_q.size(), 0);

        // Overflow averted by a pop coinciding with the 5th push
        i_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, -1, -1);
        send_frame(8'h05, 1'b1, STOP_CYC, -1);
        idle(2);
        check("coinc_count", o_count, 4);
        check("coinc_no_ovf", o_overflow, 0);
        i_ready = 1'b1;
        idle(6);
        check("coinc_drained", o_count, 0);

        // Randomized frames, gaps and consumer stalls
        rnd_on = 1;
        fork
            begin
                while (rnd_on) begin
                    @(posedge clk);
                    #1;
                    i_ready = 1'($urandom_range(0, 1));
                end
            end
        join_none
        for (int f = 0; f < 20; f++) begin
            send_frame(8'($urandom), 1'b1, -1, -1);
            idle($urandom_range(0, 20));
        end
        rnd_on = 0;
        idle(3);
        i_ready = 1'b1;
        idle(8);
        check("rand_queue_empty", exp_q.size(), 0);
        check("rand_count", o_count, 0);
        check("rand_ferr", ferr_seen, exp_ferr);
        check("rand_ovf", o_overflow, exp_ovf);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
